// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, fetch FSM states, length-decode result.
package cpu_pkg;
  localparam int LEN_W = 3;

  localparam logic [7:0] OP_PUSH_BASE    = 8'h50;
  localparam logic [7:0] OP_POP_BASE     = 8'h58;
  localparam logic [7:0] OP_NOP          = 8'h90;
  localparam logic [7:0] OP_RET          = 8'hC3;
  localparam logic [7:0] OP_MOV_RM_R     = 8'h89;
  localparam logic [7:0] OP_MOV_R_RM     = 8'h8B;
  localparam logic [7:0] OP_MOV_IMM_BASE = 8'hB8;
  localparam logic [7:0] OP_CALL         = 8'hE8;
  localparam logic [7:0] OP_JMP          = 8'hE9;

  typedef enum logic [1:0] {FETCH, EXT, OUT, HALT} fetch_state_e;

  typedef struct packed {
    logic             legal;
    logic [LEN_W-1:0] len;
    logic             has_modrm;
    logic             has_imm;
  } len_info_t;
endpackage

// File: rtl/inst_length_decode.sv
// Combinational length decode for the supported IA-32 subset.
module inst_length_decode
  import cpu_pkg::*;
(
  input  logic [7:0] opcode,
  input  logic [7:0] modrm,
  output len_info_t  info
);
  always_comb begin
    info = '{legal: 1'b0, len: LEN_W'(1), has_modrm: 1'b0, has_imm: 1'b0};
    if (opcode[7:3] == OP_PUSH_BASE[7:3] || opcode[7:3] == OP_POP_BASE[7:3] ||
        opcode == OP_NOP || opcode == OP_RET) begin
      info.legal = 1'b1;
    end else if (opcode == OP_MOV_RM_R || opcode == OP_MOV_R_RM) begin
      // Only register-to-register forms; memory operands would need SIB/disp decode.
      info.legal     = (modrm[7:6] == 2'b11);
      info.len       = LEN_W'(2);
      info.has_modrm = 1'b1;
    end else if (opcode[7:3] == OP_MOV_IMM_BASE[7:3] || opcode == OP_CALL || opcode == OP_JMP) begin
      info.legal   = 1'b1;
      info.len     = LEN_W'(5);
      info.has_imm = 1'b1;
    end
  end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: length-decodes the 4-byte window at pc_addr, refetches for 5-byte
// instructions, and hands one assembled instruction per valid/ready handshake.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic             clk,
  input  logic             reset,
  output logic [7:0]       pc_addr,
  input  logic [31:0]      ope,
  input  logic             jump_valid,
  input  logic [7:0]       jump_target,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [7:0]       inst_pc,
  output logic [7:0]       inst_opcode,
  output logic [7:0]       inst_modrm,
  output logic [31:0]      inst_imm,
  output logic [LEN_W-1:0] inst_len,
  output logic             illegal
);
  fetch_state_e state;
  len_info_t    dec;
  logic         straddle;

  inst_length_decode u_dec (
    .opcode (ope[31:24]),
    .modrm  (ope[23:16]),
    .info   (dec)
  );

  // Instruction must end at or before 0x100; wrapping into 0x00 is a fault.
  assign straddle = ({1'b0, pc_addr} + {{(9-LEN_W){1'b0}}, dec.len}) > 9'd256;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      pc_addr     <= RESET_PC;
      inst_valid  <= 1'b0;
      inst_pc     <= '0;
      inst_opcode <= '0;
      inst_modrm  <= '0;
      inst_imm    <= '0;
      inst_len    <= '0;
      illegal     <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (jump_valid) begin
            pc_addr <= jump_target;
          end else if (!dec.legal || straddle) begin
            illegal <= 1'b1;
            state   <= HALT;
          end else begin
            inst_pc     <= pc_addr;
            inst_opcode <= ope[31:24];
            inst_len    <= dec.len;
            inst_modrm  <= dec.has_modrm ? ope[23:16] : 8'h00;
            if (dec.has_imm) begin
              // Low three imm bytes are in this window; the top byte needs a second fetch.
              inst_imm <= {8'h00, ope[7:0], ope[15:8], ope[23:16]};
              pc_addr  <= pc_addr + 8'd4;
              state    <= EXT;
            end else begin
              inst_imm   <= '0;
              inst_valid <= 1'b1;
              state      <= OUT;
            end
          end
        end
        EXT: begin
          if (jump_valid) begin
            pc_addr <= jump_target;
            state   <= FETCH;
          end else begin
            inst_imm[31:24] <= ope[31:24];
            pc_addr         <= inst_pc;
            inst_valid      <= 1'b1;
            state           <= OUT;
          end
        end
        OUT: begin
          if (jump_valid) begin
            pc_addr    <= jump_target;
            inst_valid <= 1'b0;
            state      <= FETCH;
          end else if (inst_ready) begin
            pc_addr    <= inst_pc + {{(8-LEN_W){1'b0}}, inst_len};
            inst_valid <= 1'b0;
            state      <= FETCH;
          end
        end
        HALT: ;
      endcase
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a byte-array memory model and an
// expected-instruction scoreboard checked at each handshake.
module tb_instruction_fetch;
  import cpu_pkg::*;

  typedef struct {
    logic [7:0]  pc;
    logic [7:0]  op;
    logic [7:0]  modrm;
    logic [31:0] imm;
    logic [2:0]  len;
  } exp_t;

  logic             clk, reset;
  logic [7:0]       pc_addr;
  logic [31:0]      ope;
  logic             jump_valid;
  logic [7:0]       jump_target;
  logic             inst_valid, inst_ready;
  logic [7:0]       inst_pc, inst_opcode, inst_modrm;
  logic [31:0]      inst_imm;
  logic [LEN_W-1:0] inst_len;
  logic             illegal;

  logic [7:0] mem [0:255];
  exp_t       q[$];
  int         errors = 0;
  int         checks = 0;
  int         hs_cnt = 0;

  instruction_fetch #(.RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .pc_addr(pc_addr), .ope(ope),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_pc(inst_pc), .inst_opcode(inst_opcode), .inst_modrm(inst_modrm),
    .inst_imm(inst_imm), .inst_len(inst_len), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    logic [7:0] a1, a2, a3;
    a1 = pc_addr + 8'd1;
    a2 = pc_addr + 8'd2;
    a3 = pc_addr + 8'd3;
    ope = {mem[pc_addr], mem[a1], mem[a2], mem[a3]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void push(logic [7:0] pc, logic [7:0] op, logic [7:0] modrm,
                               logic [31:0] imm, logic [2:0] len);
    exp_t e;
    e.pc = pc; e.op = op; e.modrm = modrm; e.imm = imm; e.len = len;
    q.push_back(e);
  endfunction

  // Called at a negedge with inputs already driven: scores the coming edge's handshake.
  task automatic tick();
    exp_t e;
    if (inst_valid && inst_ready) begin
      hs_cnt++;
      if (q.size() == 0) chk("unexpected_inst", 32'(inst_pc), 32'hFFFF_FFFF);
      else begin
        e = q.pop_front();
        chk("inst_pc", 32'(inst_pc), 32'(e.pc));
        chk("inst_opcode", 32'(inst_opcode), 32'(e.op));
        chk("inst_modrm", 32'(inst_modrm), 32'(e.modrm));
        chk("inst_imm", inst_imm, e.imm);
        chk("inst_len", 32'(inst_len), 32'(e.len));
      end
    end
    @(negedge clk);
  endtask

  task automatic run_until(input int n);
    int c = 0;
    while (q.size() > n && c < 200) begin tick(); c++; end
    chk("drain", q.size(), n);
  endtask

  task automatic wait_valid();
    int c = 0;
    while (!inst_valid && c < 20) begin tick(); c++; end
    chk("valid_seen", 32'(inst_valid), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1; jump_valid = 1'b0; jump_target = 8'h00; inst_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h90;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_prog1();
    mem[0] = 8'h55; mem[1] = 8'h89; mem[2] = 8'hE5; mem[3] = 8'hB8; mem[4] = 8'h02;
    mem[5] = 8'h00; mem[6] = 8'h00; mem[7] = 8'h00; mem[8] = 8'h5D; mem[9] = 8'hC3;
    push(8'h00, 8'h55, 8'h00, 32'h0, 3'd1);
    push(8'h01, 8'h89, 8'hE5, 32'h0, 3'd2);
    push(8'h03, 8'hB8, 8'h00, 32'h0000_0002, 3'd5);
    push(8'h08, 8'h5D, 8'h00, 32'h0, 3'd1);
    push(8'h09, 8'hC3, 8'h00, 32'h0, 3'd1);
  endtask

  initial begin
    int hs0;
    // Reset state
    do_reset();
    chk("rst_pc_addr", 32'(pc_addr), 32'h00);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_fields", {inst_pc, inst_opcode, inst_modrm, 5'b0, inst_len}, 32'h0);
    chk("rst_imm", inst_imm, 32'h0);

    // Program stream with ready held high
    reset = 1'b1; load_prog1(); @(negedge clk); reset = 1'b0;
    inst_ready = 1'b1;
    run_until(0);
    chk("next_pc_after_c3", 32'(pc_addr), 32'h0A);

    // Back-pressure on the 5-byte instruction
    do_reset(); load_prog1();
    inst_ready = 1'b1;
    run_until(3);
    inst_ready = 1'b0;
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 32'(inst_valid), 1);
      chk("hold_pc", 32'(inst_pc), 32'(q[0].pc));
      chk("hold_imm", inst_imm, q[0].imm);
      chk("hold_len", 32'(inst_len), 32'(q[0].len));
      tick();
    end
    inst_ready = 1'b1;
    tick();
    chk("pc_after_b8", 32'(pc_addr), 32'h08);
    run_until(0);

    // Redirect coincident with handshake on a call
    do_reset();
    mem[0] = 8'hE8; mem[1] = 8'h10; mem[2] = 8'h32; mem[3] = 8'h54; mem[4] = 8'h76;
    push(8'h00, 8'hE8, 8'h00, 32'h7654_3210, 3'd5);
    hs0 = hs_cnt;
    wait_valid();
    inst_ready = 1'b1; jump_valid = 1'b1; jump_target = 8'h15;
    tick();
    inst_ready = 1'b0; jump_valid = 1'b0;
    chk("jump_pc", 32'(pc_addr), 32'h15);
    chk("jump_drained", q.size(), 0);
    tick(); tick(); tick();
    chk("jump_hs_once", hs_cnt - hs0, 1);

    // Illegal opcode halts; redirect ignored; reset recovers
    do_reset();
    mem[4] = 8'h0F;
    for (int i = 0; i < 4; i++) push(8'(i), 8'h90, 8'h00, 32'h0, 3'd1);
    inst_ready = 1'b1;
    run_until(0);
    tick();
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_valid", 32'(inst_valid), 0);
    jump_valid = 1'b1; jump_target = 8'h20;
    tick(); tick(); tick();
    jump_valid = 1'b0;
    chk("halt_pc", 32'(pc_addr), 32'h04);
    chk("halt_flag", 32'(illegal), 1);
    chk("halt_valid", 32'(inst_valid), 0);
    reset = 1'b1; #1;
    chk("rst_clr_ill", 32'(illegal), 0);
    chk("rst_clr_pc", 32'(pc_addr), 32'h00);
    @(negedge clk); reset = 1'b0;

    // 5-byte instruction straddling 0xFF -> 0x00
    do_reset();
    mem[8'hFC] = 8'hB8;
    jump_valid = 1'b1; jump_target = 8'hFC;
    tick();
    jump_valid = 1'b0;
    tick();
    chk("straddle_ill", 32'(illegal), 1);
    chk("straddle_valid", 32'(inst_valid), 0);

    // 1-byte instruction at 0xFF is fine and wraps the PC
    do_reset();
    mem[8'hFF] = 8'h55;
    push(8'hFF, 8'h55, 8'h00, 32'h0, 3'd1);
    jump_valid = 1'b1; jump_target = 8'hFF;
    tick();
    jump_valid = 1'b0; inst_ready = 1'b1;
    run_until(0);
    chk("wrap_pc", 32'(pc_addr), 32'h00);
    chk("wrap_ill", 32'(illegal), 0);

    // Reset during EXT aborts the pending instruction
    do_reset();
    mem[0] = 8'hB8; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h33; mem[4] = 8'h44;
    inst_ready = 1'b1;
    hs0 = hs_cnt;
    tick();
    chk("ext_pc", 32'(pc_addr), 32'h04);
    reset = 1'b1; #1;
    chk("ext_rst_pc", 32'(pc_addr), 32'h00);
    chk("ext_rst_imm", inst_imm, 32'h0);
    chk("ext_rst_fields", {inst_pc, inst_opcode, inst_modrm, 5'b0, inst_len}, 32'h0);
    chk("ext_rst_valid", 32'(inst_valid), 0);
    tick(); tick();
    chk("ext_no_inst", hs_cnt - hs0, 0);
    chk("ext_valid_held", 32'(inst_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
